// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: one state per cycle, driving every datapath enable and mux select.
// Build option: define ILLEGAL_TRAP_EN to park unknown opcodes in a TRAP state; otherwise they retire as NOPs.
module multicycle_controller #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adrsrc,
   output logic       memwr,
   output logic       IRwrite,
   output logic       PCwrite,
   output logic       regwr,
   output logic [1:0] ALUsrcA,
   output logic [1:0] ALUsrcB,
   output logic [1:0] ALUctrl,
   output logic [1:0] resultsrc,
   output logic [1:0] immsrc,
   output logic [3:0] state,
   output logic       trap
);

   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_MEMADR   = 4'd2;
   localparam logic [3:0] ST_MEMREAD  = 4'd3;
   localparam logic [3:0] ST_MEMWB    = 4'd4;
   localparam logic [3:0] ST_MEMWRITE = 4'd5;
   localparam logic [3:0] ST_EXECR    = 4'd6;
   localparam logic [3:0] ST_EXECI    = 4'd7;
   localparam logic [3:0] ST_ALUWB    = 4'd8;
   localparam logic [3:0] ST_BEQ      = 4'd9;
   localparam logic [3:0] ST_JAL      = 4'd10;
   localparam logic [3:0] ST_TRAP     = 4'd11;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   logic [3:0] state_q;
   logic [3:0] next_state;

   logic       fsm_mem_req;
   logic       fsm_adrsrc;
   logic       fsm_memwr;
   logic       fsm_irwrite;
   logic       fsm_pcwrite;
   logic       fsm_regwr;
   logic [1:0] fsm_srca;
   logic [1:0] fsm_srcb;
   logic [1:0] fsm_aluctrl;
   logic [1:0] fsm_resultsrc;
   logic [1:0] alu_dec;
`ifdef ILLEGAL_TRAP_EN
   logic       fsm_trap;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state_q <= RESET_STATE;
      else      state_q <= next_state;
   end

   assign state = state_q;

   // funct7_5 only selects subtract for R-type; addi never subtracts.
   always_comb begin
      alu_dec = ALU_ADD;
      case (funct3)
         3'b000:  alu_dec = (op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_dec = ALU_AND;
         3'b110:  alu_dec = ALU_OR;
         default: alu_dec = ALU_ADD;
      endcase
   end

   always_comb begin
      immsrc = IMM_I;
      case (op)
         OP_SW:   immsrc = IMM_S;
         OP_BEQ:  immsrc = IMM_B;
         OP_JAL:  immsrc = IMM_J;
         default: immsrc = IMM_I;
      endcase
   end

   // Memory handshake: mem_req is held until a cycle with mem_ready high, which
   // completes the request; mem_ready is don't-care whenever mem_req is low.
   always_comb begin
      next_state    = ST_FETCH;
      fsm_mem_req   = 1'b0;
      fsm_adrsrc    = 1'b0;
      fsm_memwr     = 1'b0;
      fsm_irwrite   = 1'b0;
      fsm_pcwrite   = 1'b0;
      fsm_regwr     = 1'b0;
      fsm_srca      = SRCA_PC;
      fsm_srcb      = SRCB_RS2;
      fsm_aluctrl   = ALU_ADD;
      fsm_resultsrc = RES_ALUOUT;
`ifdef ILLEGAL_TRAP_EN
      fsm_trap      = 1'b0;
`endif
      case (state_q)
         ST_FETCH: begin
            fsm_mem_req   = 1'b1;
            fsm_srca      = SRCA_PC;
            fsm_srcb      = SRCB_FOUR;
            fsm_aluctrl   = ALU_ADD;
            fsm_resultsrc = RES_ALU;
            fsm_irwrite   = mem_ready;
            fsm_pcwrite   = mem_ready;
            next_state    = mem_ready ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            fsm_srca    = SRCA_OLDPC;
            fsm_srcb    = SRCB_IMM;
            fsm_aluctrl = ALU_ADD;
            case (op)
               OP_LW, OP_SW: next_state = ST_MEMADR;
               OP_R:         next_state = ST_EXECR;
               OP_I:         next_state = ST_EXECI;
               OP_BEQ:       next_state = ST_BEQ;
               OP_JAL:       next_state = ST_JAL;
`ifdef ILLEGAL_TRAP_EN
               default:      next_state = ST_TRAP;
`else
               default:      next_state = ST_FETCH;
`endif
            endcase
         end
         ST_MEMADR: begin
            fsm_srca    = SRCA_RS1;
            fsm_srcb    = SRCB_IMM;
            fsm_aluctrl = ALU_ADD;
            next_state  = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
         end
         ST_MEMREAD: begin
            fsm_mem_req   = 1'b1;
            fsm_adrsrc    = 1'b1;
            fsm_resultsrc = RES_ALUOUT;
            next_state    = mem_ready ? ST_MEMWB : ST_MEMREAD;
         end
         ST_MEMWB: begin
            fsm_resultsrc = RES_RDATA;
            fsm_regwr     = 1'b1;
            next_state    = ST_FETCH;
         end
         ST_MEMWRITE: begin
            // The write strobe is held across wait cycles; memory must tolerate it.
            fsm_mem_req   = 1'b1;
            fsm_adrsrc    = 1'b1;
            fsm_memwr     = 1'b1;
            fsm_resultsrc = RES_ALUOUT;
            next_state    = mem_ready ? ST_FETCH : ST_MEMWRITE;
         end
         ST_EXECR: begin
            fsm_srca    = SRCA_RS1;
            fsm_srcb    = SRCB_RS2;
            fsm_aluctrl = alu_dec;
            next_state  = ST_ALUWB;
         end
         ST_EXECI: begin
            fsm_srca    = SRCA_RS1;
            fsm_srcb    = SRCB_IMM;
            fsm_aluctrl = alu_dec;
            next_state  = ST_ALUWB;
         end
         ST_ALUWB: begin
            fsm_resultsrc = RES_ALUOUT;
            fsm_regwr     = 1'b1;
            next_state    = ST_FETCH;
         end
         ST_BEQ: begin
            fsm_srca      = SRCA_RS1;
            fsm_srcb      = SRCB_RS2;
            fsm_aluctrl   = ALU_SUB;
            fsm_resultsrc = RES_ALUOUT;
            fsm_pcwrite   = zero;
            next_state    = ST_FETCH;
         end
         ST_JAL: begin
            // PC takes the target computed into ALUOut during DECODE; ALUWB then writes oldPC+4.
            fsm_srca      = SRCA_OLDPC;
            fsm_srcb      = SRCB_FOUR;
            fsm_aluctrl   = ALU_ADD;
            fsm_resultsrc = RES_ALUOUT;
            fsm_pcwrite   = 1'b1;
            next_state    = ST_ALUWB;
         end
         ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
            fsm_trap   = 1'b1;
            next_state = ST_TRAP;
`else
            next_state = ST_FETCH;
`endif
         end
         default: next_state = ST_FETCH;
      endcase
   end

   // During reset all strobes are suppressed and the selects show their FETCH values.
   assign mem_req   = rst & fsm_mem_req;
   assign memwr     = rst & fsm_memwr;
   assign IRwrite   = rst & fsm_irwrite;
   assign PCwrite   = rst & fsm_pcwrite;
   assign regwr     = rst & fsm_regwr;
   assign adrsrc    = rst ? fsm_adrsrc    : 1'b0;
   assign ALUsrcA   = rst ? fsm_srca      : SRCA_PC;
   assign ALUsrcB   = rst ? fsm_srcb      : SRCB_FOUR;
   assign ALUctrl   = rst ? fsm_aluctrl   : ALU_ADD;
   assign resultsrc = rst ? fsm_resultsrc : RES_ALU;
`ifdef ILLEGAL_TRAP_EN
   assign trap      = rst & fsm_trap;
`else
   assign trap      = 1'b0;
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle variant of the RV32I core. It shares one unified instruction/data memory and one ALU across several cycles per instruction.
- Decodes op/funct3/funct7_5/zero and drives every datapath enable and mux select, one state per cycle.
- Waits on a memory ready handshake for instruction fetch, load and store.
- Replaces the single-cycle control_unit when the core is built in multicycle mode.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); the only legal value is 0.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- op  input  7  instr[6:0] from the instruction register.
- funct3  input  3  instr[14:12].
- funct7_5  input  1  instr[30].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request strobe.
- adrsrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memwr  output  1  memory write strobe.
- IRwrite  output  1  load the instruction register and oldPC.
- PCwrite  output  1  load the PC.
- regwr  output  1  register file write enable.
- ALUsrcA  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 register.
- ALUsrcB  output  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- ALUctrl  output  2  ALU operation: 00 = add, 01 = sub, 10 = and, 11 = or.
- resultsrc  output  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- immsrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- state  output  4  current state, for debug.
- trap  output  1  illegal-opcode trap flag; tied 0 unless ILLEGAL_TRAP_EN is defined.

Behaviour:
- State register: on a clk edge with rst == 0, state becomes FETCH. All outputs are combinational from state and inputs (Moore, plus the zero and mem_ready qualifiers below).
- While rst == 0, mem_req, memwr, IRwrite, PCwrite and regwr are forced to 0. Every other output takes its FETCH value.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Opcodes: lw=0000011, sw=0100011, R=0110011, I-ALU=0010011, beq=1100011, jal=1101111.
- Default for any output not listed in a state: 0.
- FETCH:
  - Drives mem_req=1, adrsrc=0, ALUsrcA=00, ALUsrcB=10, ALUctrl=00, resultsrc=10.
  - IRwrite and PCwrite equal mem_ready.
  - Goes to DECODE when mem_ready, otherwise stays in FETCH.
- DECODE: ALUsrcA=01, ALUsrcB=01, ALUctrl=00 (branch target computed into ALUOut). Next state by op:
  - lw or sw -> MEMADR
  - R -> EXECR
  - I-ALU -> EXECI
  - beq -> BEQ
  - jal -> JAL
  - any other opcode -> see Optional Feature.
- MEMADR: ALUsrcA=10, ALUsrcB=01, add. Goes to MEMREAD if op==lw, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. Stays until mem_ready, then goes to MEMWB.
- MEMWB: resultsrc=01, regwr=1. Goes to FETCH.
- MEMWRITE: mem_req=1, adrsrc=1, memwr=1, resultsrc=00. Stays until mem_ready, then goes to FETCH.
  - memwr stays high on every wait cycle; the memory must tolerate a held write.
- EXECR: ALUsrcA=10, ALUsrcB=00, ALU decode. Goes to ALUWB.
- EXECI: ALUsrcA=10, ALUsrcB=01, ALU decode. Goes to ALUWB.
- ALU decode:
  - funct3 000 -> sub when op==R and funct7_5==1, otherwise add.
  - funct3 111 -> and.
  - funct3 110 -> or.
  - any other funct3 -> add.
  - For I-ALU, funct7_5 is ignored (addi never subtracts).
- ALUWB: resultsrc=00, regwr=1. Goes to FETCH.
- BEQ: ALUsrcA=10, ALUsrcB=00, sub, resultsrc=00, PCwrite=zero. Goes to FETCH.
- JAL: ALUsrcA=01, ALUsrcB=10, add, resultsrc=00, PCwrite=1 (PC takes the target held in ALUOut). Goes to ALUWB, which writes oldPC+4 to rd.
- immsrc is decoded from op in every state:
  - lw and I-ALU -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - other opcodes -> 00
- Latency in cycles, with mem_ready=1 every cycle: lw 5; sw 4; R and I 4; beq 3; jal 4. Each memory wait cycle adds 1.
- mem_ready is ignored in any state where mem_req==0.
- Reset in any state, including memory wait states, gives FETCH on the next edge. No write strobe may be issued in the reset cycle.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE goes to TRAP.
  - TRAP drives trap=1 and all strobes 0, and holds until reset.
- Undefined:
  - An unknown op in DECODE returns to FETCH as a NOP: no regwr, memwr or PCwrite. The PC has already advanced by 4 in FETCH.
  - trap is tied to 0.
  - State 11 is unreachable; if entered it goes to FETCH.

Test Plan:
- Reset: hold rst=0 for 2 cycles while mem_ready=1 -> state=0, IRwrite=PCwrite=regwr=memwr=mem_req=0; release -> FETCH strobes assert on the next cycle.
- add, sub: fetch R-type (op=0110011, funct3=000, funct7_5=1), mem_ready=1 -> state sequence 0,1,6,8,0; ALUctrl=01 in EXECR; regwr=1 only in ALUWB.
- lw with wait: lw, mem_ready held 0 for 3 cycles in MEMREAD -> state stays 3 for 3 cycles, then 4 with resultsrc=01, regwr=1; 8 cycles in total.
- sw: sw with mem_ready=1 -> states 0,1,2,5,0; memwr=1 and adrsrc=1 only in state 5; immsrc=01 throughout.
- beq: zero=1 -> PCwrite=1 in state 9; repeat with zero=0 -> PCwrite=0 in state 9; both return to 0 after 3 cycles.
- Illegal opcode: op=1111111 -> with ILLEGAL_TRAP_EN, state=11 and trap=1 held for 10+ cycles until rst=0; without the macro, states 0,1,0 and no regwr or memwr.
